// File: rtl/uart_tx8_if.sv
// uart_tx8_if: parallel load handshake and serial line of the 8N1 transmitter
interface uart_tx8_if;
  logic [7:0] in;
  logic       load;
  logic       tx;
  logic       busy;
  modport master (output in, load, input tx, busy);
  modport slave  (input in, load, output tx, busy);
endinterface

// File: rtl/uart_tx8.sv
// uart_tx8: 8N1 UART transmitter, one frame per accepted load, busy as handshake
module uart_tx8 #(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx8_if.slave  bus
);
  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      sh, sh_n;
  logic            tx_r, busy_r, term;
  assign term = cnt == CW'(BAUD_DIV - 1);
  always_comb begin
    state_n = state;
    cnt_n   = term ? '0 : cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.load) begin
          state_n = START;
          sh_n    = bus.in;
        end
      end
      START: if (term) begin
        state_n = DATA;
        idx_n   = 3'd0;
      end
      DATA: if (term) begin
        if (idx == 3'd7) state_n = STOP;
        else begin
          idx_n = idx + 3'd1;
          sh_n  = sh >> 1;
        end
      end
      STOP: if (term) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // tx/busy are registered from the next state so the line changes on the same edge as the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= 3'd0;
      sh     <= 8'd0;
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      tx_r   <= (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
      busy_r <= state_n != IDLE;
    end
  end
  assign bus.tx   = tx_r;
  assign bus.busy = busy_r;
endmodule
